regfile_mp_clr: RTL

- Parametrised integer register file: 2 combinational read ports, 1 write port.
- Adds hardwired-zero register 0, same-cycle write-to-read bypass, a sequential clear/initialise sweep after reset, and a busy/ready indication.
- Sits between decode (read addresses) and writeback (write port) of the datapath; the pipeline stalls while ready is low.

---
 rtl/regfile_mp_clr_if.sv | 26 ++
 rtl/regfile_mp_clr.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_mp_clr_if.sv
// Register-file bus: two read ports, one write port, plus status.
// The master side is the datapath (decode/writeback) and the slave side is the file.
interface regfile_mp_clr_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            we;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            wr_drop;

  modport master (
    output rs1, rs2, we, rd, wdata,
    input  rdata1, rdata2, ready, wr_drop
  );

  modport slave (
    input  rs1, rs2, we, rd, wdata,
    output rdata1, rdata2, ready, wr_drop
  );
endinterface

// File: rtl/regfile_mp_clr.sv
// Integer register file: 2 combinational read ports, 1 write port.
// Register 0 is hardwired to zero, writes bypass to same-cycle reads, and after
// reset a sequential sweep loads every register with the fill value before the
// file reports ready.
module regfile_mp_clr #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int INIT_MODE = 0
) (
  input logic            clk,
  input logic            reset,
  regfile_mp_clr_if.slave bus
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  // Register count widened by one bit so NREGS == 2**AW still compares correctly.
  localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            wr_drop_q, wr_drop_d;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] regs [NREGS];

  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  // An address names a real, writable register: not r0 and below NREGS.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  // Control state, sweep pointer and drop pulse; reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Next-state logic and selection of the single storage write per cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.rd;
    mem_wdata = bus.wdata;

    unique case (state_q)
      CLEAR: begin
        // r0 storage is never touched; reads of r0 are forced to zero anyway.
        mem_we    = (ptr_q != '0);
        mem_addr  = ptr_q;
        mem_wdata = (INIT_MODE != 0) ? XLEN'(ptr_q) : '0;
        ptr_d     = ptr_q + 1'b1;
        wr_drop_d = bus.we;
        if (ptr_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.we) begin
          if (in_range(bus.rd)) begin
            mem_we = 1'b1;
          end else begin
            wr_drop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage array: one write per cycle from either the sweep or the user port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the post-reset sweep initialises it and
    // reads are masked to zero until the sweep has finished.
    if (mem_we) begin
      regs[mem_addr] <= mem_wdata;
    end
  end

  // Read port 1: zero outside RUN or for r0/out-of-range, else bypass or array.
  always_comb begin
    rdata1 = '0;
    if (state_q == RUN && in_range(bus.rs1)) begin
      rdata1 = (bus.we && bus.rd == bus.rs1) ? bus.wdata : regs[bus.rs1];
    end
  end

  // Read port 2: identical selection, independent address.
  always_comb begin
    rdata2 = '0;
    if (state_q == RUN && in_range(bus.rs2)) begin
      rdata2 = (bus.we && bus.rd == bus.rs2) ? bus.wdata : regs[bus.rs2];
    end
  end

  assign bus.rdata1  = rdata1;
  assign bus.rdata2  = rdata2;
  assign bus.ready   = (state_q == RUN);
  assign bus.wr_drop = wr_drop_q;

endmodule
